// File: rtl/countdown_ctrl_if.sv
// Control and display bus for the two-digit countdown controller.
// The master side issues start/pause/load pulses and the BCD preset;
// the slave side returns the current count digits and the status flags.
interface countdown_ctrl_if;
    logic       start;
    logic       pause;
    logic       load;
    logic [3:0] load_h;
    logic [3:0] load_l;
    logic [3:0] TimeH;
    logic [3:0] TimeL;
    logic       running;
    logic       done;

    modport master (
        output start,
        output pause,
        output load,
        output load_h,
        output load_l,
        input  TimeH,
        input  TimeL,
        input  running,
        input  done
    );

    modport slave (
        input  start,
        input  pause,
        input  load,
        input  load_h,
        input  load_l,
        output TimeH,
        output TimeL,
        output running,
        output done
    );
endinterface

// File: rtl/countdown_ctrl.sv
// Two-digit BCD countdown sequencer: owns the count, derives the
// decrement tick from the system clock and runs the
// IDLE/RUN/PAUSED/DONE state machine. All outputs are registered.
module countdown_ctrl #(
    parameter int         TICK_DIV = 50000000,
    parameter logic [3:0] INIT_H   = 4'd6,
    parameter logic [3:0] INIT_L   = 4'd0
) (
    input  logic          clock,
    input  logic          reset,
    countdown_ctrl_if.slave bus
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // One BCD step down; the low digit borrows from the high digit.
    function automatic logic [7:0] bcd_dec(input logic [3:0] h, input logic [3:0] l);
        logic [7:0] r;
        if (l != 4'd0) begin
            r = {h, l - 4'd1};
        end else begin
            r = {h - 4'd1, 4'd9};
        end
        return r;
    endfunction

    state_t        state_q,    state_d;
    logic [3:0]    time_h_q,   time_h_d;
    logic [3:0]    time_l_q,   time_l_d;
    logic [3:0]    preset_h_q, preset_h_d;
    logic [3:0]    preset_l_q, preset_l_d;
    logic [PW-1:0] presc_q,    presc_d;
    logic          running_q,  running_d;
    logic          done_q,     done_d;

    logic          load_ok;
    logic          count_zero;
    logic          tick;
    logic [7:0]    dec_val;

    // Input qualification and the decremented count candidate.
    always_comb begin
        load_ok    = bus.load && (bus.load_h <= 4'd9) && (bus.load_l <= 4'd9);
        count_zero = (time_h_q == 4'd0) && (time_l_q == 4'd0);
        tick       = (state_q == S_RUN) && (presc_q == PRESC_LAST);
        dec_val    = bcd_dec(time_h_q, time_l_q);
    end

    // Next-state logic; priority within each state is load > pause > start.
    always_comb begin
        state_d    = state_q;
        time_h_d   = time_h_q;
        time_l_d   = time_l_q;
        preset_h_d = preset_h_q;
        preset_l_d = preset_l_q;
        presc_d    = presc_q;

        case (state_q)
            S_IDLE: begin
                if (load_ok) begin
                    time_h_d   = bus.load_h;
                    time_l_d   = bus.load_l;
                    preset_h_d = bus.load_h;
                    preset_l_d = bus.load_l;
                    presc_d    = '0;
                end else if (bus.start && !count_zero) begin
                    state_d = S_RUN;
                    presc_d = '0;
                end
            end
            S_RUN: begin
                // Loads and starts are ignored while counting.
                if (tick) begin
                    presc_d  = '0;
                    time_h_d = dec_val[7:4];
                    time_l_d = dec_val[3:0];
                    if (dec_val == 8'h00) begin
                        state_d = S_DONE;
                    end else if (bus.pause) begin
                        state_d = S_PAUSED;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                    if (bus.pause) begin
                        state_d = S_PAUSED;
                    end
                end
            end
            S_PAUSED: begin
                // Prescaler is held here so a resume keeps the partial second.
                if (load_ok) begin
                    time_h_d   = bus.load_h;
                    time_l_d   = bus.load_l;
                    preset_h_d = bus.load_h;
                    preset_l_d = bus.load_l;
                    presc_d    = '0;
                    state_d    = S_IDLE;
                end else if (bus.start) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (load_ok) begin
                    time_h_d   = bus.load_h;
                    time_l_d   = bus.load_l;
                    preset_h_d = bus.load_h;
                    preset_l_d = bus.load_l;
                    presc_d    = '0;
                    state_d    = S_IDLE;
                end else if (bus.start) begin
                    time_h_d = preset_h_q;
                    time_l_d = preset_l_q;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    // State, count, preset, prescaler and status flags register together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            time_h_q   <= INIT_H;
            time_l_q   <= INIT_L;
            preset_h_q <= INIT_H;
            preset_l_q <= INIT_L;
            presc_q    <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_h_q   <= time_h_d;
            time_l_q   <= time_l_d;
            preset_h_q <= preset_h_d;
            preset_l_q <= preset_l_d;
            presc_q    <= presc_d;
            running_q  <= running_d;
            done_q     <= done_d;
        end
    end

    assign bus.TimeH   = time_h_q;
    assign bus.TimeL   = time_l_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
Sequencing controller for the two-digit countdown. It owns the BCD count value, generates the one-second decrement tick from the system clock, and runs a start/pause/load/done state machine. Its TimeH/TimeL outputs drive the high and low digit inputs of the two-digit seven-segment display driver directly. The done flag goes to the alarm/LED logic.

Parameters:
TICK_DIV, 50000000, clock cycles per count decrement (1 s at 50 MHz); range 2..2^26; benches use 4
INIT_H, 4'd6, high BCD digit loaded at reset (0..9)
INIT_L, 4'd0, low BCD digit loaded at reset (0..9)

Ports:
clock    input   1   system clock; all logic on its rising edge
reset    input   1   synchronous, active-high reset
start    input   1   single-cycle pulse (debounced upstream): start, resume, or re-arm
pause    input   1   single-cycle pulse: freeze the countdown
load     input   1   single-cycle pulse: capture load_h/load_l as the new preset
load_h   input   4   BCD preset, high digit
load_l   input   4   BCD preset, low digit
TimeH    output  4   current count, high BCD digit (registered)
TimeL    output  4   current count, low BCD digit (registered)
running  output  1   1 while in RUN
done     output  1   1 while in DONE

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - state = IDLE; TimeH = INIT_H; TimeL = INIT_L.
  - preset register = {INIT_H, INIT_L}; prescaler = 0; running = 0; done = 0.
- Reset overrides every other input in the same cycle. A reset during RUN or PAUSED aborts the countdown.
- Prescaler:
  - Width is ceil(log2(TICK_DIV)).
  - Increments only in RUN. Held, not cleared, in PAUSED.
  - Cleared on entry to RUN from IDLE and on any load.
  - tick = 1 in the cycle where prescaler == TICK_DIV-1 in RUN. On that cycle the prescaler wraps to 0.
- BCD decrement on tick:
  - If TimeL != 0: TimeL -= 1.
  - Else: TimeL = 9 and TimeH -= 1.
  - The count never leaves 00..99 and never produces a non-BCD digit.
- Load validity: a load is valid only if load_h <= 9 and load_l <= 9. An invalid load is ignored completely (no output or state change).
- States:
  - IDLE:
    - Valid load -> TimeH/TimeL and preset take load_h/load_l; stay IDLE.
    - start with count != 00 -> RUN; prescaler cleared.
    - start with count == 00 -> ignored.
  - RUN:
    - On tick, decrement. If the decremented value is 00 -> DONE on the same edge (running falls, done rises).
    - pause -> PAUSED.
    - start and load are ignored.
  - PAUSED:
    - start -> RUN; prescaler resumes from its held value.
    - Valid load -> new value and preset loaded, prescaler cleared, -> IDLE.
    - pause is ignored.
  - DONE:
    - Count holds at 00; done = 1 for as long as the state is held.
    - start -> TimeH/TimeL reloaded from the preset, -> IDLE.
    - Valid load -> new value and preset loaded, -> IDLE.
    - pause is ignored.
- Simultaneous events, by priority:
  - reset > load > pause > start.
  - In RUN, tick and pause in the same cycle: decrement is applied, then PAUSED. If that decrement reaches 00, DONE wins over PAUSED.
  - In PAUSED, start and load in the same cycle: load wins -> IDLE.
  - In DONE, start and load in the same cycle: load wins (new preset is used).
- running = (state == RUN); done = (state == DONE). Both are registered and change on the same edge as the state.
- Latency:
  - Count outputs update on the clock edge that samples load or tick.
  - running updates on the edge that samples start.

Test Plan:
- Reset: TICK_DIV=4, INIT=60. Assert reset 2 cycles -> TimeH=6, TimeL=0, running=0, done=0. start -> running=1 next edge; first decrement (TimeH=5, TimeL=9) exactly 4 cycles after start.
- Digit borrow: load 10, start -> sequence 10, 09, 08 … 01, one step every 4 cycles. On the 00 edge done=1 and running=0 together; count holds at 00 for 20 further cycles.
- Pause/resume: load 05, start, wait 6 cycles (count 04, prescaler=2), pause -> count and prescaler frozen for 50 cycles. start -> next decrement (to 03) after exactly 2 cycles.
- Invalid and ignored loads: in IDLE, load_h=4'hA, load_l=3 -> no change. In RUN, valid load 42 -> no change, countdown continues.
- Re-arm from DONE: preset 02, run to done. start -> IDLE, count 02, done=0. Second start -> runs again to 00.
- Collisions: tick and pause on the same cycle at count 01 -> DONE, not PAUSED. In PAUSED, start and load 33 together -> IDLE with count 33. Reset mid-RUN -> INIT value, IDLE.
